// File: rtl/cam_capture_ctrl.sv
// Camera capture controller: sequences camera power-up, then on request stores one
// frame of RGB565 pixels (two bytes each) from an asynchronous camera bus into a frame buffer.
module cam_capture_ctrl #(
  parameter int H_ACTIVE   = 160,
  parameter int V_ACTIVE   = 120,
  parameter int PWR_CYCLES = 1000,
  parameter int ADDR_W     = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              Vsync,
  input  logic              Href,
  input  logic              Pclk,
  input  logic [7:0]        Imagen,
  output logic              Xclk,
  output logic              Reset,
  output logic              PWDN,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data
);

  localparam int CNT_W = (PWR_CYCLES > 1) ? $clog2(PWR_CYCLES) : 1;
  localparam int COL_W = $clog2(H_ACTIVE + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PWR_CYCLES - 1);
  localparam logic [COL_W-1:0]  COL_END   = COL_W'(H_ACTIVE);
  localparam logic [ADDR_W:0]   FRAME_END = (ADDR_W + 1)'(H_ACTIVE * V_ACTIVE);

  typedef enum logic [2:0] {
    S_PWR_DOWN,
    S_CAM_RST,
    S_SETTLE,
    S_IDLE,
    S_WAIT_VS,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt;

  // Synchronized camera bus plus one-cycle-old copies for edge detection
  logic [1:0] vs_sync, hr_sync, pc_sync;
  logic [7:0] img_d1, img_d2;
  logic       vs_q, hr_q, pc_q;
  logic       vs_s, hr_s, pc_s;
  logic       vs_rise, vs_fall, hr_fall, pc_event;

  // Capture datapath; the address keeps one extra bit so a frame that exactly
  // fills the address space still saturates instead of wrapping.
  logic             phase;
  logic [COL_W-1:0] col;
  logic [7:0]       hi_byte;
  logic [ADDR_W:0]  addr_q;
  logic [ADDR_W:0]  addr_eff;
  logic             byte_ok, addr_ok, col_ok;

  // NOTE: sequential state always uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would make the 2-FF chain collapse into one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_sync <= '0;
      hr_sync <= '0;
      pc_sync <= '0;
      img_d1  <= '0;
      img_d2  <= '0;
      vs_q    <= 1'b0;
      hr_q    <= 1'b0;
      pc_q    <= 1'b0;
    end else begin
      vs_sync <= {vs_sync[0], Vsync};
      hr_sync <= {hr_sync[0], Href};
      pc_sync <= {pc_sync[0], Pclk};
      img_d1  <= Imagen;
      img_d2  <= img_d1;
      vs_q    <= vs_sync[1];
      hr_q    <= hr_sync[1];
      pc_q    <= pc_sync[1];
    end
  end

  assign vs_s     = vs_sync[1];
  assign hr_s     = hr_sync[1];
  assign pc_s     = pc_sync[1];
  assign vs_rise  = vs_s & ~vs_q;
  assign vs_fall  = ~vs_s & vs_q;
  assign hr_fall  = ~hr_s & hr_q;
  assign pc_event = pc_s & ~pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) Xclk <= 1'b0;
    else      Xclk <= ~Xclk;
  end

  // State register; the phase counter restarts on every state change
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_PWR_DOWN;
      cnt   <= '0;
    end else begin
      state <= state_d;
      if ((state inside {S_PWR_DOWN, S_CAM_RST, S_SETTLE}) && (state_d == state))
        cnt <= cnt + CNT_W'(1);
      else
        cnt <= '0;
    end
  end

  // NOTE: every always_comb output gets a default first; a missed branch then
  // holds the default instead of inferring a latch.
  always_comb begin
    state_d = state;
    PWDN    = 1'b0;
    Reset   = 1'b1;
    busy    = 1'b1;
    done    = 1'b0;
    case (state)
      S_PWR_DOWN: begin
        PWDN  = 1'b1;
        Reset = 1'b0;
        if (cnt == CNT_LAST) state_d = S_CAM_RST;
      end
      S_CAM_RST: begin
        Reset = 1'b0;
        if (cnt == CNT_LAST) state_d = S_SETTLE;
      end
      S_SETTLE:  if (cnt == CNT_LAST) state_d = S_IDLE;
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_WAIT_VS;
      end
      S_WAIT_VS: if (vs_fall) state_d = S_CAPTURE;
      S_CAPTURE: if (vs_rise) state_d = S_DONE;
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_PWR_DOWN;
    endcase
  end

  // A frame-ending Vsync edge wins over a coincident byte
  assign byte_ok  = (state == S_CAPTURE) && !vs_rise && pc_event && hr_s;
  assign addr_ok  = addr_q < FRAME_END;
  assign col_ok   = col < COL_END;
  assign addr_eff = addr_q + {{ADDR_W{1'b0}}, wr_en};
  assign wr_addr  = addr_q[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase   <= 1'b0;
      col     <= '0;
      hi_byte <= '0;
      addr_q  <= '0;
      wr_en   <= 1'b0;
      wr_data <= '0;
      err     <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      // Address advances the cycle after the write so wr_addr matches wr_en
      if (wr_en) addr_q <= addr_q + (ADDR_W + 1)'(1);

      if (state == S_IDLE && start) begin
        err    <= 1'b0;
        addr_q <= '0;
      end

      if (state == S_WAIT_VS && vs_fall) begin
        phase <= 1'b0;
        col   <= '0;
      end

      if (state == S_CAPTURE) begin
        if (vs_rise) begin
          if (addr_eff != FRAME_END) err <= 1'b1;
        end else if (hr_fall) begin
          phase <= 1'b0;
          col   <= '0;
          if (phase) err <= 1'b1;
        end else if (byte_ok) begin
          if (!phase) begin
            hi_byte <= img_d2;
            phase   <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (col_ok) col <= col + COL_W'(1);
            if (col_ok && addr_ok) begin
              wr_en   <= 1'b1;
              wr_data <= {hi_byte, img_d2};
            end else begin
              err <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Bench for cam_capture_ctrl: small frame geometry, camera bus driven at clk/2,
// frame-buffer writes checked against a scoreboard filled as bytes are sent.
module tb_cam_capture_ctrl;

  localparam int H     = 4;
  localparam int V     = 2;
  localparam int PWR   = 4;
  localparam int AW    = 4;
  localparam int FRAME = H * V;

  logic          clk = 1'b0;
  logic          rst, start, Vsync, Href, Pclk;
  logic [7:0]    Imagen;
  logic          busy, done, err, Xclk, Reset, PWDN, wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;

  cam_capture_ctrl #(
    .H_ACTIVE(H), .V_ACTIVE(V), .PWR_CYCLES(PWR), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .Vsync(Vsync), .Href(Href), .Pclk(Pclk), .Imagen(Imagen),
    .Xclk(Xclk), .Reset(Reset), .PWDN(PWDN),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  wr_t  exp_q[$];
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   wr_cnt    = 0;
  int   done_cnt  = 0;
  int   exp_dones = 0;

  // Reference model of the capture path
  int         m_addr, m_col;
  bit         m_err, m_phase;
  logic [7:0] m_hi;

  // Write and done monitor, sampled just after each active edge
  always @(posedge clk) begin
    wr_t e;
    #1;
    if (wr_en === 1'b1) begin
      wr_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL wr_unexpected: got addr=%0d data=%h, expected no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if (wr_addr !== e.addr || wr_data !== e.data)
          $display("FAIL wr_data: got addr=%0d data=%h, expected addr=%0d data=%h",
                   wr_addr, wr_data, e.addr, e.data);
        else
          n_pass++;
      end
    end
    if (done === 1'b1) done_cnt++;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    Imagen = b;
    Pclk   = 1'b1;
    @(negedge clk);
    Pclk   = 1'b0;
  endtask

  task automatic send_line(input int nbytes);
    logic [7:0] b;
    @(negedge clk) Href = 1'b1;
    repeat (2) @(negedge clk);
    m_phase = 1'b0;
    m_col   = 0;
    for (int i = 0; i < nbytes; i++) begin
      b = 8'(i);
      if (!m_phase) begin
        m_hi    = b;
        m_phase = 1'b1;
      end else begin
        m_phase = 1'b0;
        if (m_col < H && m_addr < FRAME) begin
          exp_q.push_back({AW'(m_addr), m_hi, b});
          m_addr++;
        end else begin
          m_err = 1'b1;
        end
        m_col++;
      end
      send_byte(b);
    end
    if (m_phase) m_err = 1'b1;
    @(negedge clk) Href = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic vsync_pulse();
    @(negedge clk) Vsync = 1'b1;
    repeat (3) @(negedge clk);
    Vsync = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic start_frame();
    m_addr = 0;
    m_err  = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    vsync_pulse();
  endtask

  task automatic end_frame(input string tag);
    bit   seen;
    logic err_d;
    seen  = 1'b0;
    err_d = 1'bx;
    exp_dones++;
    @(negedge clk) Vsync = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        seen  = 1'b1;
        err_d = err;
      end
    end
    n_checks++;
    if (seen) n_pass++;
    else $display("FAIL %s_done_timeout: got no done in 20 cycles, expected a done pulse", tag);
    n_checks++;
    if (err_d === m_err) n_pass++;
    else $display("FAIL %s_err: got err=%b at done, expected %b", tag, err_d, m_err);
    @(posedge clk);
    #1;
    n_checks++;
    if ({done, busy} === 2'b00) n_pass++;
    else $display("FAIL %s_after_done: got done=%b busy=%b, expected 0 0", tag, done, busy);
    @(negedge clk) Vsync = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0 && wr_addr === AW'(m_addr)) n_pass++;
    else $display("FAIL %s_final: got pending=%0d wr_addr=%0d, expected 0 and %0d",
                  tag, exp_q.size(), wr_addr, m_addr);
    n_checks++;
    if (done_cnt == exp_dones) n_pass++;
    else $display("FAIL %s_done_count: got %0d, expected %0d", tag, done_cnt, exp_dones);
  endtask

  task automatic test_reset();
    logic [3:0] exp_v;
    rst = 1'b0; start = 1'b0; Vsync = 1'b0; Href = 1'b0; Pclk = 1'b0; Imagen = '0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({PWDN, Reset, Xclk, busy, done, err, wr_en, wr_addr, wr_data} !==
        {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, {AW{1'b0}}, 16'h0000})
      $display("FAIL reset_state: got PWDN=%b Reset=%b Xclk=%b busy=%b done=%b err=%b wr_en=%b addr=%0d data=%h",
               PWDN, Reset, Xclk, busy, done, err, wr_en, wr_addr, wr_data);
    else n_pass++;
    @(negedge clk) rst = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) @(posedge clk);
      #1;
      exp_v = {k < 4, k >= 8, k < 12, k[0]};
      n_checks++;
      if ({PWDN, Reset, busy, Xclk} !== exp_v)
        $display("FAIL powerup_c%0d: got PWDN/Reset/busy/Xclk=%b, expected %b",
                 k, {PWDN, Reset, busy, Xclk}, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_full_frame(input string tag);
    int base;
    base = wr_cnt;
    start_frame();
    send_line(8);
    send_line(8);
    end_frame(tag);
    n_checks++;
    if (wr_cnt - base == 8) n_pass++;
    else $display("FAIL %s_writes: got %0d, expected 8", tag, wr_cnt - base);
  endtask

  task automatic test_long_line();
    int base;
    base = wr_cnt;
    start_frame();
    send_line(10);
    n_checks++;
    if (err === 1'b1 && wr_cnt - base == 4) n_pass++;
    else $display("FAIL long_line: got err=%b writes=%0d, expected 1 and 4", err, wr_cnt - base);
    end_frame("long_line");
  endtask

  task automatic test_odd_bytes();
    int base;
    base = wr_cnt;
    start_frame();
    send_line(7);
    n_checks++;
    if (err === 1'b1 && wr_cnt - base == 3) n_pass++;
    else $display("FAIL odd_line: got err=%b writes=%0d, expected 1 and 3", err, wr_cnt - base);
    send_line(8);
    end_frame("odd_bytes");
  endtask

  task automatic test_start_ignored();
    m_addr = 0;
    m_err  = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    #1;
    n_checks++;
    if ({err, wr_addr, busy} === {1'b0, {AW{1'b0}}, 1'b1}) n_pass++;
    else $display("FAIL start_clear: got err=%b wr_addr=%0d busy=%b, expected 0 0 1", err, wr_addr, busy);
    @(negedge clk) Vsync = 1'b1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (2) @(negedge clk);
    Vsync = 1'b0;
    repeat (4) @(negedge clk);
    send_line(8);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    #1;
    n_checks++;
    if (busy === 1'b1 && done === 1'b0) n_pass++;
    else $display("FAIL start_in_capture: got busy=%b done=%b, expected 1 0", busy, done);
    send_line(8);
    end_frame("start_busy");
  endtask

  task automatic test_reset_mid_capture();
    int  base, k;
    bit  seen;
    base = wr_cnt;
    start_frame();
    @(negedge clk) Href = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.push_back({AW'(0), 16'h0A0B});
    send_byte(8'h0A);
    send_byte(8'h0B);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (wr_en === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen) n_pass++;
    else $display("FAIL mid_write_timeout: got no wr_en in 10 cycles, expected one");
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if ({PWDN, Reset, wr_en, busy, done, wr_addr} === {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {AW{1'b0}}}) n_pass++;
    else $display("FAIL mid_reset: got PWDN=%b Reset=%b wr_en=%b busy=%b done=%b addr=%0d, expected 1 0 0 1 0 0",
                  PWDN, Reset, wr_en, busy, done, wr_addr);
    send_byte(8'h0C);
    send_byte(8'h0D);
    @(negedge clk) Href = 1'b0;
    @(negedge clk) rst = 1'b1;
    #1;
    n_checks++;
    if ({PWDN, Reset} === 2'b10) n_pass++;
    else $display("FAIL mid_repowerup: got PWDN=%b Reset=%b, expected 1 0", PWDN, Reset);
    k = 0;
    while (busy === 1'b1 && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_checks++;
    if (k == 12) n_pass++;
    else $display("FAIL mid_busy_fall: got busy low after %0d cycles, expected 12", k);
    n_checks++;
    if (wr_cnt - base == 1 && exp_q.size() == 0) n_pass++;
    else $display("FAIL mid_writes: got %0d writes pending=%0d, expected 1 and 0",
                  wr_cnt - base, exp_q.size());
  endtask

  initial begin
    test_reset();
    test_full_frame("full_frame");
    test_long_line();
    test_odd_bytes();
    test_start_ignored();
    test_reset_mid_capture();
    test_full_frame("recover");
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cam_capture_ctrl.md
CAM_CAPTURE_CTRL -- requirements
Module: cam_capture_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 160, pixels per line to store.
REQ-002 SHALL have parameter V_ACTIVE, default 120, lines per frame to store.
REQ-003 SHALL have parameter PWR_CYCLES, default 1000, clk cycles per power-up phase (minimum 2).
REQ-004 SHALL have parameter ADDR_W, default 15, write-address width; 2^ADDR_W >= H_ACTIVE*V_ACTIVE.
REQ-005 SHALL have port clk  in  1  system clock; the only clock, all logic on rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  in  1  single-cycle request to capture one frame.
REQ-008 SHALL have port busy  out  1  high in every state except IDLE.
REQ-009 SHALL have port done  out  1  one-cycle pulse at end of capture.
REQ-010 SHALL have port err  out  1  frame-size mismatch flag for the last capture.
REQ-011 SHALL have ports Vsync, Href, Pclk  in  1 each  camera timing, asynchronous to clk.
REQ-012 SHALL have port Imagen  in  8  camera pixel byte, valid on Pclk rising edge.
REQ-013 SHALL have port Xclk  out  1  camera master clock, clk/2.
REQ-014 SHALL have port Reset  out  1  camera reset, active-low.
REQ-015 SHALL have port PWDN  out  1  camera power-down, active-high.
REQ-016 SHALL have ports wr_en out 1, wr_addr out ADDR_W, wr_data out 16  frame-buffer write port.

Function
REQ-017 Xclk SHALL toggle every clk cycle whenever rst is high.
REQ-018 Vsync, Href, Pclk SHALL pass through 2-FF synchronizers; Imagen SHALL be delayed by the same 2 stages so it stays aligned.
REQ-019 A Pclk rising event SHALL be detected as synced Pclk 1 now and 0 the previous cycle; clk frequency >= 2x Pclk is required.
REQ-020 States SHALL be PWR_DOWN, CAM_RST, SETTLE, IDLE, WAIT_VS, CAPTURE, DONE.
REQ-021 PWR_DOWN: PWDN=1, Reset=0; after PWR_CYCLES cycles go to CAM_RST.
REQ-022 CAM_RST: PWDN=0, Reset=0; after PWR_CYCLES cycles go to SETTLE.
REQ-023 SETTLE: PWDN=0, Reset=1; after PWR_CYCLES cycles go to IDLE; Reset=1, PWDN=0 in all later states.
REQ-024 IDLE: start=1 SHALL go to WAIT_VS, clear err and wr_addr; start SHALL be ignored in every other state.
REQ-025 WAIT_VS: a synced Vsync falling edge SHALL go to CAPTURE with byte phase=0 and column=0.
REQ-026 CAPTURE: each Pclk event with synced Href=1 SHALL latch a byte; phase 0 stores the high byte, phase 1 forms the pixel {high, current}.
REQ-027 On pixel formation, if column < H_ACTIVE and wr_addr < H_ACTIVE*V_ACTIVE, wr_en SHALL pulse for one cycle with wr_data = pixel and the current wr_addr; wr_addr SHALL then increment.
REQ-028 Pixels beyond H_ACTIVE in a line, or beyond H_ACTIVE*V_ACTIVE in a frame, SHALL be discarded and set err.
REQ-029 A synced Href falling edge SHALL reset phase and column; a dangling high byte SHALL be dropped and set err.
REQ-030 A synced Vsync rising edge in CAPTURE SHALL go to DONE; err SHALL be set if wr_addr != H_ACTIVE*V_ACTIVE.
REQ-031 DONE SHALL assert done for exactly one cycle, then return to IDLE; err SHALL hold until the next accepted start.
REQ-032 wr_addr SHALL never wrap; it saturates at H_ACTIVE*V_ACTIVE.
REQ-033 Vsync rising and a Pclk event in the same cycle: the byte SHALL be ignored and the transition to DONE SHALL take priority.

Reset
REQ-034 rst low SHALL immediately force state PWR_DOWN, PWDN=1, Reset=0, Xclk=0, wr_en=0, wr_addr=0, wr_data=0, done=0, err=0, busy=1, and clear counters and synchronizers.
REQ-035 rst asserted mid-capture SHALL abandon the frame and rerun the full power-up sequence; no wr_en SHALL follow.

Verification
REQ-036 Power-up check, PWR_CYCLES=4: release rst -> PWDN=1/Reset=0 for 4 cycles, then 0/0 for 4, then 0/1 for 4; busy falls in cycle 12; Xclk toggles every cycle throughout.
REQ-037 Full-frame check, H=4, V=2, Pclk=clk/2 pattern: start, Vsync pulse, 2 Href lines of 8 bytes 0x00..0x07 -> 8 wr_en pulses; addr 0..7; first wr_data 0x0001, last 0x0607; done pulse; err=0.
REQ-038 Long line, H=4: one line with 10 bytes -> 4 writes only, err=1 at done.
REQ-039 Odd byte count: Href falls after 7 bytes -> 3 writes for that line; err=1; next line starts at phase 0.
REQ-040 Start during busy (WAIT_VS) -> ignored; one done per accepted start; rst low mid-CAPTURE -> PWDN=1 and wr_en=0 in the same cycle.
